// File: rtl/cbus_mem_responder_pkg.sv
// Cache-bus request/response types shared by the memory responder and its masters.
package cbus_mem_responder_pkg;

  // Burst length encoding; beat count is 1, 2, 4, 8 or 16.
  typedef enum logic [2:0] {
    MLEN1  = 3'd0,
    MLEN2  = 3'd1,
    MLEN4  = 3'd2,
    MLEN8  = 3'd3,
    MLEN16 = 3'd4
  } mlen_t;

  typedef struct packed {
    logic        valid;
    logic        is_write;
    logic [2:0]  size;
    logic [31:0] addr;
    logic [3:0]  strobe;
    logic [31:0] data;
    mlen_t       len;
  } cbus_req_t;

  typedef struct packed {
    logic        ready;
    logic        last;
    logic [31:0] data;
    logic        okay;
  } cbus_resp_t;

  // Width of a beat index inside a burst (up to 16 beats).
  localparam int BEAT_W = 4;

endpackage

// File: rtl/cbus_mem_responder_ram.sv
// Word-addressed single-port backing store with byte write enables and a
// registered read port. The array is left public so benches can preload it.
module responder_ram #(
  parameter int WORDS = 4096,
  parameter int AW    = $clog2(WORDS)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          re,
  input  logic [3:0]    we,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  logic [31:0] mem [WORDS];

  // Byte-lane writes into the store.
  // NOTE: the array itself is never reset; contents survive reset and stay preloadable.
  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (we[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
    end
  end

  // Registered read; the output register is cleared so the bus data starts at zero.
  always_ff @(posedge clk) begin
    if (reset) rdata <= '0;
    else if (re) rdata <= mem[addr];
  end

endmodule

// File: rtl/cbus_mem_responder.sv
// Behavioural memory slave for the cache bus: accepts single/burst INCR
// transactions and returns beats after a fixed first-beat latency.
module cbus_mem_responder
  import cbus_mem_responder_pkg::*;
#(
  parameter int WORDS   = 4096,
  parameter int LATENCY = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  cbus_req_t  creq,
  output cbus_resp_t cresp
);

  localparam int AW = $clog2(WORDS);
  localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_BURST
  } state_t;

  // Index of the final beat (N-1) for a given burst length.
  function automatic logic [BEAT_W-1:0] len_to_last(input mlen_t len);
    case (len)
      MLEN1:   return 4'd0;
      MLEN2:   return 4'd1;
      MLEN4:   return 4'd3;
      MLEN8:   return 4'd7;
      MLEN16:  return 4'd15;
      default: return 4'd0;
    endcase
  endfunction

  state_t            state;
  logic [CW-1:0]     cnt;
  logic [AW-1:0]     base;
  logic [BEAT_W-1:0] last_idx;
  logic [BEAT_W-1:0] k;
  logic              is_wr;
  logic              ready_q;
  logic              last_q;
  logic              okay_q;
  logic              wr_pend;
  logic [AW-1:0]     wr_idx;

  logic [AW-1:0]     rd_idx;
  logic              ram_re;
  logic [3:0]        ram_we;
  logic [AW-1:0]     ram_addr;
  logic [31:0]       ram_rdata;

  // size and the low/high address bits do not take part in addressing.
  logic unused_req;
  assign unused_req = ^{creq.size, creq.addr};

  // A BURST cycle issues beat k: a read is launched on the store at the same
  // edge that raises ready, so read data and ready appear together. A write
  // beat is committed at the end of its ready cycle, which lets a reset in
  // that cycle discard the beat.
  assign rd_idx   = base + AW'(k);
  assign ram_re   = (state == S_BURST) && !is_wr;
  assign ram_we   = {4{wr_pend & ~reset}} & creq.strobe;
  assign ram_addr = wr_pend ? wr_idx : rd_idx;

  responder_ram #(
    .WORDS (WORDS),
    .AW    (AW)
  ) u_ram (
    .clk   (clk),
    .reset (reset),
    .re    (ram_re),
    .we    (ram_we),
    .addr  (ram_addr),
    .wdata (creq.data),
    .rdata (ram_rdata)
  );

  // Transaction FSM with registered response flags.
  // NOTE: all state here uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_IDLE;
      cnt      <= '0;
      base     <= '0;
      last_idx <= '0;
      k        <= '0;
      is_wr    <= 1'b0;
      ready_q  <= 1'b0;
      last_q   <= 1'b0;
      okay_q   <= 1'b0;
      wr_pend  <= 1'b0;
      wr_idx   <= '0;
    end else begin
      ready_q <= 1'b0;
      last_q  <= 1'b0;
      okay_q  <= 1'b0;
      wr_pend <= 1'b0;
      case (state)
        S_IDLE: begin
          // ready_q high here means the last beat is still on the bus; the
          // following idle cycle is the earliest point a new request is taken.
          if (creq.valid && !ready_q) begin
            is_wr    <= creq.is_write;
            base     <= creq.addr[AW+1:2];
            last_idx <= len_to_last(creq.len);
            k        <= '0;
            if (LATENCY == 1) begin
              state <= S_BURST;
            end else begin
              cnt   <= CW'(LATENCY - 1);
              state <= S_WAIT;
            end
          end
        end
        S_WAIT: begin
          cnt <= cnt - 1'b1;
          if (cnt == CW'(1)) state <= S_BURST;
        end
        S_BURST: begin
          ready_q <= 1'b1;
          okay_q  <= 1'b1;
          last_q  <= (k == last_idx);
          wr_pend <= is_wr;
          wr_idx  <= rd_idx;
          if (k == last_idx) begin
            k     <= '0;
            state <= S_IDLE;
          end else begin
            k <= k + 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign cresp.ready = ready_q;
  assign cresp.last  = last_q;
  assign cresp.okay  = okay_q;
  assign cresp.data  = ram_rdata;

endmodule

// File: tb/tb_cbus_mem_responder.sv
// Directed bench for cbus_mem_responder (WORDS=4096, LATENCY=2).
module tb_cbus_mem_responder;
  import cbus_mem_responder_pkg::*;

  localparam int LAT = 2;

  logic       clk;
  logic       reset;
  cbus_req_t  creq;
  cbus_resp_t cresp;

  int tests = 0;
  int fails = 0;

  logic [31:0] wbuf [16];
  logic [31:0] rbuf [16];

  cbus_mem_responder #(
    .WORDS   (4096),
    .LATENCY (LAT)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .creq  (creq),
    .cresp (cresp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Runs one transaction starting at the current negedge. Bit i of each mask
  // records the response in the i-th cycle after acceptance; the window ends
  // on the idle cycle that follows the last beat. Write beat b is driven in
  // the cycle where that beat's ready is seen.
  task automatic do_xfer(input logic wr, input logic [31:0] addr, input mlen_t len,
                         input logic [3:0] strb, input int n,
                         output logic [31:0] rdy_mask, output logic [31:0] last_mask,
                         output logic [31:0] okay_mask);
    int beat;
    beat      = 0;
    rdy_mask  = '0;
    last_mask = '0;
    okay_mask = '0;
    creq.valid    = 1'b1;
    creq.is_write = wr;
    creq.size     = 3'd2;
    creq.addr     = addr;
    creq.len      = len;
    creq.strobe   = strb;
    creq.data     = wbuf[0];
    for (int i = 0; i <= LAT + n; i++) begin
      @(negedge clk);
      rdy_mask[i]  = cresp.ready;
      last_mask[i] = cresp.last;
      okay_mask[i] = cresp.okay;
      if (cresp.ready) begin
        if (beat < 16) begin
          rbuf[beat] = cresp.data;
          creq.data  = wbuf[beat];
        end
        beat++;
        if (cresp.last) creq.valid = 1'b0;
      end
    end
    creq.valid = 1'b0;
  endtask

  logic [31:0] rm, lm, om;
  int          beats;
  int          guard;

  initial begin
    reset = 1'b1;
    creq  = '0;
    for (int i = 0; i < 16; i++) begin
      wbuf[i] = '0;
      rbuf[i] = '0;
    end

    // Reset state
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    check("reset_ready", {31'd0, cresp.ready}, 32'd0);
    check("reset_last",  {31'd0, cresp.last},  32'd0);
    check("reset_okay",  {31'd0, cresp.okay},  32'd0);
    check("reset_data",  cresp.data,           32'd0);
    reset = 1'b0;

    // Preload the store
    dut.u_ram.mem[12'h010] = 32'hDEAD_BEEF;
    dut.u_ram.mem[12'h020] = 32'h1122_3344;
    for (int i = 0; i < 16; i++) dut.u_ram.mem[12'h040 + i] = i;
    dut.u_ram.mem[12'hFFE] = 32'hA000_0FFE;
    dut.u_ram.mem[12'hFFF] = 32'hA000_0FFF;
    dut.u_ram.mem[12'h000] = 32'hA000_0000;
    dut.u_ram.mem[12'h001] = 32'hA000_0001;
    for (int i = 0; i < 8; i++)  dut.u_ram.mem[12'h080 + i] = 32'h0;
    for (int i = 0; i < 16; i++) dut.u_ram.mem[12'h200 + i] = 32'hC0DE_0000 + i;
    @(negedge clk);

    // Single read: first beat exactly LATENCY cycles after acceptance
    do_xfer(1'b0, 32'h0000_0040, MLEN1, 4'hF, 1, rm, lm, om);
    check("single_ready", rm, 32'h0000_0004);
    check("single_last",  lm, 32'h0000_0004);
    check("single_okay",  om, 32'h0000_0004);
    check("single_data",  rbuf[0], 32'hDEAD_BEEF);

    // Byte offset and address bits above the store are ignored
    do_xfer(1'b0, 32'h0001_0041, MLEN1, 4'hF, 1, rm, lm, om);
    check("alias_ready", rm, 32'h0000_0004);
    check("alias_data",  rbuf[0], 32'hDEAD_BEEF);

    // 16-beat burst read
    do_xfer(1'b0, 32'h0000_0100, MLEN16, 4'hF, 16, rm, lm, om);
    check("burst16_ready", rm, 32'h0003_FFFC);
    check("burst16_last",  lm, 32'h0002_0000);
    check("burst16_okay",  om, 32'h0003_FFFC);
    for (int i = 0; i < 16; i++) check($sformatf("burst16_data%0d", i), rbuf[i], i);

    // 2-beat read from the tail of the same block
    do_xfer(1'b0, 32'h0000_0138, MLEN2, 4'hF, 2, rm, lm, om);
    check("burst2_ready", rm, 32'h0000_000C);
    check("burst2_last",  lm, 32'h0000_0008);
    check("burst2_data0", rbuf[0], 32'd14);
    check("burst2_data1", rbuf[1], 32'd15);

    // Strobed write then read-back
    wbuf[0] = 32'hAABB_CCDD;
    do_xfer(1'b1, 32'h0000_0080, MLEN1, 4'b0101, 1, rm, lm, om);
    check("strobe_wr_ready", rm, 32'h0000_0004);
    check("strobe_wr_mem",   dut.u_ram.mem[12'h020], 32'h11BB_33DD);
    do_xfer(1'b0, 32'h0000_0080, MLEN1, 4'hF, 1, rm, lm, om);
    check("strobe_rd_data",  rbuf[0], 32'h11BB_33DD);

    // Wrap-around at the top of the store
    do_xfer(1'b0, 32'h0000_3FF8, MLEN4, 4'hF, 4, rm, lm, om);
    check("wrap_ready", rm, 32'h0000_003C);
    check("wrap_last",  lm, 32'h0000_0020);
    check("wrap_data0", rbuf[0], 32'hA000_0FFE);
    check("wrap_data1", rbuf[1], 32'hA000_0FFF);
    check("wrap_data2", rbuf[2], 32'hA000_0000);
    check("wrap_data3", rbuf[3], 32'hA000_0001);

    // Back-to-back 8-word write then read of the same line
    for (int i = 0; i < 8; i++) wbuf[i] = 32'h5A00_0000 + i * 32'h11;
    do_xfer(1'b1, 32'h0000_0200, MLEN8, 4'hF, 8, rm, lm, om);
    check("b2b_wr_ready", rm, 32'h0000_03FC);
    check("b2b_wr_last",  lm, 32'h0000_0200);
    do_xfer(1'b0, 32'h0000_0200, MLEN8, 4'hF, 8, rm, lm, om);
    check("b2b_rd_ready", rm, 32'h0000_03FC);
    check("b2b_rd_last",  lm, 32'h0000_0200);
    for (int i = 0; i < 8; i++)
      check($sformatf("b2b_rd_data%0d", i), rbuf[i], 32'h5A00_0000 + i * 32'h11);

    // Reset during beat 3 of a 16-beat write
    for (int i = 0; i < 16; i++) wbuf[i] = 32'hF000_0000 + i;
    creq.valid    = 1'b1;
    creq.is_write = 1'b1;
    creq.size     = 3'd2;
    creq.addr     = 32'h0000_0800;
    creq.len      = MLEN16;
    creq.strobe   = 4'hF;
    creq.data     = wbuf[0];
    beats = 0;
    guard = 0;
    while (guard < 40 && !reset) begin
      @(negedge clk);
      guard++;
      if (cresp.ready) begin
        if (beats == 3) begin
          reset = 1'b1;
        end else begin
          creq.data = wbuf[beats];
          beats++;
        end
      end
    end
    check("rst_reached_beat3", {31'd0, reset}, 32'd1);
    @(negedge clk);
    check("rst_ready", {31'd0, cresp.ready}, 32'd0);
    check("rst_last",  {31'd0, cresp.last},  32'd0);
    reset      = 1'b0;
    creq.valid = 1'b0;
    for (int i = 0; i < 16; i++)
      check($sformatf("rst_mem%0d", i), dut.u_ram.mem[12'h200 + i],
            (i < 3) ? 32'hF000_0000 + i : 32'hC0DE_0000 + i);
    @(negedge clk);

    // Normal service after the aborted burst
    do_xfer(1'b0, 32'h0000_0800, MLEN4, 4'hF, 4, rm, lm, om);
    check("post_rst_ready", rm, 32'h0000_003C);
    check("post_rst_last",  lm, 32'h0000_0020);
    check("post_rst_data0", rbuf[0], 32'hF000_0000);
    check("post_rst_data1", rbuf[1], 32'hF000_0001);
    check("post_rst_data2", rbuf[2], 32'hF000_0002);
    check("post_rst_data3", rbuf[3], 32'hC0DE_0003);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
